// File: rtl/uart_word_tx.sv
// uart_word_tx
// 16-bit word UART transmitter. One word is accepted through a valid/ready
// handshake. It is sent on TxData as two back-to-back 8N1 frames: the high
// byte goes first, and each byte is sent LSB first.
//
// Handshake: a word is accepted on any rising edge where i_valid and o_ready
// are both high. o_ready is high only in IDLE. i_valid while busy is ignored
// (not queued), and i_data is only sampled on the accepting edge.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   i_data     word to send (sampled at acceptance)
//   i_valid    word request
//   o_ready    idle, can accept a word
//   o_busy     transmission in progress (~o_ready)
//   o_done     one-cycle pulse when the low byte's stop bit completes
//   TxData     serial line, idle high, registered
//   state_dbg  current FSM state (debug visibility)
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        TxData,
  output logic [1:0]  state_dbg
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             byte_idx;
  logic [7:0]       shift;
  // The high byte goes straight into the shift register at acceptance.
  // Only the low byte has to be held until the second frame starts.
  logic [7:0]       hold_lo;
  logic             tx;
  logic             done;

  logic tc;
  assign tc = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= 1'b0;
      shift    <= '0;
      hold_lo  <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      // The bit-period counter only runs while a frame is on the line.
      if (state != S_IDLE) begin
        cnt <= tc ? '0 : cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (i_valid) begin
            hold_lo  <= i_data[7:0];
            shift    <= i_data[15:8];
            byte_idx <= 1'b0;
            bit_idx  <= '0;
            cnt      <= '0;
            tx       <= 1'b0;
            state    <= S_START;
          end
        end

        S_START: begin
          if (tc) begin
            tx    <= shift[0];
            state <= S_DATA;
          end
        end

        S_DATA: begin
          if (tc) begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              // TxData is registered, so the next bit is taken from
              // shift[1] while the shift register moves right.
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end
        end

        S_STOP: begin
          if (tc) begin
            if (!byte_idx) begin
              // The low byte's start bit follows the stop bit directly,
              // with no idle gap between the two frames.
              byte_idx <= 1'b1;
              shift    <= hold_lo;
              bit_idx  <= '0;
              tx       <= 1'b0;
              state    <= S_START;
            end else begin
              tx    <= 1'b1;
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready   = (state == S_IDLE);
  assign o_busy    = ~o_ready;
  assign o_done    = done;
  assign TxData    = tx;
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_word_tx.sv
// Testbench for uart_word_tx with CLKS_PER_BIT = 4. The expected line
// waveform is built from the framing rules: start, high byte LSB first,
// stop, start, low byte LSB first, stop. Each bit lasts N cycles.
module tb_uart_word_tx;

  localparam int N = 4;

  logic        clk;
  logic        reset;
  logic [15:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic        o_busy;
  logic        o_done;
  logic        TxData;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_expected = 0;

  logic exp_q[$];

  uart_word_tx #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .TxData   (TxData),
    .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  // Count o_done pulses away from the active edge.
  always @(negedge clk) begin
    if (o_done === 1'b1) done_seen++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the 20 line bits of one word.
  task automatic build_expected(input logic [15:0] w);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[8+i]);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
    exp_q.push_back(1'b1);
  endtask

  // Driver: present the word and wait (bounded) for the accepting edge.
  // On return the time is 1 unit after acceptance edge E.
  task automatic send(input logic [15:0] w, input bit keep_valid);
    int waited;
    i_data  = w;
    i_valid = 1'b1;
    waited  = 0;
    while (o_ready !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    chk("accept_wait", {15'd0, o_ready}, 16'd1);
    step();
    if (!keep_valid) begin
      i_valid = 1'b0;
      i_data  = 16'($urandom);
    end
  endtask

  // Scoreboard: starting at E+1, compare the line for 'ncyc' cycles.
  // If the whole word is covered, the done/idle state at E+20N is checked too.
  // poke >= 0 pulses i_valid with FFFF for one cycle at that cycle index.
  task automatic check_stream(input logic [15:0] w, input int poke, input int ncyc);
    logic eb;
    build_expected(w);
    for (int c = 0; c < ncyc; c++) begin
      eb = exp_q[c / N];
      chk($sformatf("tx_%0h_bit%0d_c%0d", w, c / N, c % N), {15'd0, TxData}, {15'd0, eb});
      chk($sformatf("busy_%0h_c%0d", w, c), {15'd0, o_busy}, 16'd1);
      if (c == poke) begin
        i_valid = 1'b1;
        i_data  = 16'hFFFF;
      end else if (poke >= 0 && c == poke + 1) begin
        i_valid = 1'b0;
        i_data  = 16'($urandom);
      end
      step();
    end
    if (ncyc == 20 * N) begin
      chk("end_tx",    {15'd0, TxData},  16'd1);
      chk("end_ready", {15'd0, o_ready}, 16'd1);
      chk("end_busy",  {15'd0, o_busy},  16'd0);
      chk("end_done",  {15'd0, o_done},  16'd1);
      done_expected++;
    end
  endtask

  initial begin
    logic [15:0] w;
    int gap;
    reset   = 1'b0;
    i_valid = 1'b0;
    i_data  = 16'h0000;

    // Reset state
    repeat (3) step();
    chk("rst_tx",    {15'd0, TxData},  16'd1);
    chk("rst_ready", {15'd0, o_ready}, 16'd1);
    chk("rst_busy",  {15'd0, o_busy},  16'd0);
    chk("rst_done",  {15'd0, o_done},  16'd0);
    reset = 1'b1;
    repeat (2) step();
    chk("idle_tx", {15'd0, TxData}, 16'd1);

    // Single word 20F2
    send(16'h20F2, 1'b0);
    check_stream(16'h20F2, -1, 20 * N);
    step();
    chk("done_one_cycle", {15'd0, o_done}, 16'd0);

    // Back-to-back: i_valid stays high across both words
    send(16'h1104, 1'b1);
    i_data = 16'h0113;
    check_stream(16'h1104, -1, 20 * N);
    step();
    i_valid = 1'b0;
    i_data  = 16'($urandom);
    chk("b2b_second_start", {15'd0, TxData}, 16'd0);
    check_stream(16'h0113, -1, 20 * N);
    step();
    chk("b2b_done_low", {15'd0, o_done}, 16'd0);

    // Busy rejection: a FFFF request mid-frame must be ignored
    repeat (3) step();
    send(16'h0024, 1'b0);
    check_stream(16'h0024, 6 * N + 1, 20 * N);
    step();
    chk("rej_done_low", {15'd0, o_done}, 16'd0);
    repeat (4) step();
    chk("rej_not_sent", {15'd0, o_busy}, 16'd0);
    chk("rej_done_count", 16'(done_seen), 16'(done_expected));

    // Reset during the low byte's DATA state
    send(16'h0064, 1'b0);
    check_stream(16'h0064, -1, 13 * N + 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_tx",    {15'd0, TxData},  16'd1);
    chk("mid_rst_ready", {15'd0, o_ready}, 16'd1);
    chk("mid_rst_busy",  {15'd0, o_busy},  16'd0);
    chk("mid_rst_done",  {15'd0, o_done},  16'd0);
    repeat (2) step();
    #3;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("post_rst_idle_c%0d", c), {15'd0, TxData, o_busy}, 16'b10);
    end
    chk("mid_rst_done_count", 16'(done_seen), 16'(done_expected));
    send(16'h0064, 1'b0);
    check_stream(16'h0064, -1, 20 * N);
    step();

    // Random words, random idle gaps, random rejected requests
    for (int n = 0; n < 6; n++) begin
      gap = $urandom_range(0, 5);
      repeat (gap) step();
      w = 16'($urandom);
      send(w, 1'b0);
      if ($urandom_range(0, 1) == 1)
        check_stream(w, $urandom_range(0, 20 * N - 4), 20 * N);
      else
        check_stream(w, -1, 20 * N);
      step();
      chk($sformatf("rand%0d_done_low", n), {15'd0, o_done}, 16'd0);
    end

    repeat (4) step();
    chk("final_done_count", 16'(done_seen), 16'(done_expected));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
